// File: rtl/fp32_pkg.sv
// Shared FP32 field layout, constants, sequencer state encoding and NaN test.
// Latency: none (package only).
// Backpressure: not applicable.
package fp32_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int MAG_W  = EXP_W + MANT_W;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_CMP,
    ST_DONE
  } state_t;

  // NaN: exponent all ones with a nonzero mantissa (infinities excluded).
  function automatic logic is_nan(input logic [31:0] v);
    return (v[MAG_W-1 -: EXP_W] == {EXP_W{1'b1}}) && (v[MANT_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp32_ord_cmp.sv
// Ordered compare of two non-NaN FP32 values a vs b, giving gt/lt/eq.
// Latency: CMP_LAT cycles from in_vld to out_vld.
// Backpressure: none; the owner must be ready for the result; flush drops all in-flight work.
module fp32_ord_cmp
  import fp32_pkg::*;
#(
  parameter int CMP_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_vld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_vld,
  output logic        gt,
  output logic        lt,
  output logic        eq
);

  logic c_gt, c_lt, c_eq;
  logic a_neg, b_neg;
  logic [MAG_W-1:0] a_mag, b_mag;

  logic [CMP_LAT-1:0] vld_q;
  logic [2:0]         res_q [CMP_LAT];

  assign a_neg = a[31];
  assign b_neg = b[31];
  assign a_mag = a[MAG_W-1:0];
  assign b_mag = b[MAG_W-1:0];

  // Sign-magnitude ordering; both zeros are equal regardless of sign.
  always_comb begin
    c_gt = 1'b0;
    c_lt = 1'b0;
    c_eq = 1'b0;
    if ((a_mag == '0) && (b_mag == '0)) begin
      c_eq = 1'b1;
    end else if (a_neg != b_neg) begin
      c_gt = b_neg;
      c_lt = a_neg;
    end else if (a_mag == b_mag) begin
      c_eq = 1'b1;
    end else if (a_neg) begin
      c_gt = (a_mag < b_mag);
      c_lt = (a_mag > b_mag);
    end else begin
      c_gt = (a_mag > b_mag);
      c_lt = (a_mag < b_mag);
    end
  end

  // Delay line carrying valid and the {gt,lt,eq} result; flush clears valids.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= '0;
      for (int i = 0; i < CMP_LAT; i++) res_q[i] <= 3'b000;
    end else begin
      vld_q[0] <= in_vld;
      res_q[0] <= {c_gt, c_lt, c_eq};
      for (int i = 1; i < CMP_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
  end

  assign out_vld      = vld_q[CMP_LAT-1];
  assign {gt, lt, eq} = res_q[CMP_LAT-1];

endmodule

// File: rtl/fp32_vec_maxmin_seq.sv
// Reduces a streamed FP32 vector to its max or min element and that element's index.
// Latency: 1 cycle per first/NaN element, CMP_LAT+1 per compared element; o_done 1 cycle after the last step.
// Backpressure: s_ready only in ACCEPT; the source holds s_valid/s_data while s_ready is low.
module fp32_vec_maxmin_seq
  import fp32_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int CMP_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_res,
  output logic [LEN_W-1:0] o_idx,
  output logic             o_nan,
  output logic             o_len_err
);

  state_t           state;
  logic             mode;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] cnt_nxt;
  logic [31:0]      best;
  logic [LEN_W-1:0] best_idx;
  logic             best_valid;
  logic             nan_seen;
  logic [31:0]      cand;
  logic [LEN_W-1:0] cand_idx;

  logic             abort_hit;
  logic             launch;
  logic             cmp_vld, cmp_gt, cmp_lt, cmp_eq;
  logic             take;

  // Running best after this cycle's update, also used to form the result on the DONE transition.
  logic [31:0]      nb_val;
  logic [LEN_W-1:0] nb_idx;
  logic             nb_bv;
  logic             nb_nan;

  assign cnt_nxt   = count + {{(LEN_W-1){1'b0}}, 1'b1};
  assign abort_hit = i_abort && (state != ST_IDLE);
  assign launch    = (state == ST_ACCEPT) && s_valid && !is_nan(s_data) && best_valid && !abort_hit;
  // Strict ordering only: a tie keeps the earlier index.
  assign take      = !cmp_eq && ((mode == MODE_MIN) ? cmp_lt : cmp_gt);

  fp32_ord_cmp #(.CMP_LAT(CMP_LAT)) u_cmp (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort_hit),
    .in_vld  (launch),
    .a       (s_data),
    .b       (best),
    .out_vld (cmp_vld),
    .gt      (cmp_gt),
    .lt      (cmp_lt),
    .eq      (cmp_eq)
  );

  // Next running best: first non-NaN element seeds it, a winning compare replaces it.
  always_comb begin
    nb_val = best;
    nb_idx = best_idx;
    nb_bv  = best_valid;
    nb_nan = nan_seen;
    if ((state == ST_ACCEPT) && s_valid) begin
      if (is_nan(s_data)) begin
        nb_nan = 1'b1;
      end else if (!best_valid) begin
        nb_val = s_data;
        nb_idx = count;
        nb_bv  = 1'b1;
      end
    end
    if ((state == ST_CMP) && cmp_vld && take) begin
      nb_val = cand;
      nb_idx = cand_idx;
    end
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_nan      <= 1'b0;
      o_len_err  <= 1'b0;
      o_res      <= '0;
      o_idx      <= '0;
      mode       <= MODE_MAX;
      len        <= '0;
      count      <= '0;
      best       <= '0;
      best_idx   <= '0;
      best_valid <= 1'b0;
      nan_seen   <= 1'b0;
      cand       <= '0;
      cand_idx   <= '0;
    end else begin
      o_done     <= 1'b0;
      best       <= nb_val;
      best_idx   <= nb_idx;
      best_valid <= nb_bv;
      nan_seen   <= nb_nan;
      if (abort_hit) begin
        state   <= ST_IDLE;
        s_ready <= 1'b0;
        o_busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              mode       <= i_mode;
              len        <= i_len;
              count      <= '0;
              best_valid <= 1'b0;
              best_idx   <= '0;
              nan_seen   <= 1'b0;
              o_len_err  <= 1'b0;
              o_busy     <= 1'b1;
              if (i_len == '0) begin
                state     <= ST_DONE;
                o_done    <= 1'b1;
                o_len_err <= 1'b1;
                o_res     <= QNAN;
                o_idx     <= '0;
                o_nan     <= 1'b0;
              end else begin
                state   <= ST_ACCEPT;
                s_ready <= 1'b1;
              end
            end
          end
          ST_ACCEPT: begin
            if (s_valid) begin
              count <= cnt_nxt;
              if (launch) begin
                cand     <= s_data;
                cand_idx <= count;
                state    <= ST_CMP;
                s_ready  <= 1'b0;
              end else if (cnt_nxt == len) begin
                state   <= ST_DONE;
                s_ready <= 1'b0;
                o_done  <= 1'b1;
                o_res   <= nb_bv ? nb_val : QNAN;
                o_idx   <= nb_bv ? nb_idx : '0;
                o_nan   <= nb_nan;
              end
            end
          end
          ST_CMP: begin
            if (cmp_vld) begin
              if (count == len) begin
                state  <= ST_DONE;
                o_done <= 1'b1;
                o_res  <= nb_bv ? nb_val : QNAN;
                o_idx  <= nb_bv ? nb_idx : '0;
                o_nan  <= nb_nan;
              end else begin
                state   <= ST_ACCEPT;
                s_ready <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
          default: begin
            state   <= ST_IDLE;
            s_ready <= 1'b0;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp32_vec_maxmin_seq.sv
// Directed bench for the FP32 vector max/min sequencer.
// Latency: checks element spacing and last-handshake-to-done timing.
// Backpressure: source keeps s_valid high and holds data until accepted.
module tb_fp32_vec_maxmin_seq;

  localparam int LEN_W   = 8;
  localparam int CMP_LAT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_mode, i_abort;
  logic [LEN_W-1:0] i_len;
  logic             s_valid, s_ready;
  logic [31:0]      s_data;
  logic             o_busy, o_done, o_nan, o_len_err;
  logic [31:0]      o_res;
  logic [LEN_W-1:0] o_idx;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] vec [256];
  int          gap_before [256];
  logic [31:0] got_res;
  logic [7:0]  got_idx;
  logic        got_nan, got_lerr;
  int          done_cnt, done_cyc, last_hs, ready_cnt;
  logic        fired;
  logic [4:0]  snap_flags;
  logic [31:0] snap_res;
  logic [7:0]  snap_idx;

  fp32_vec_maxmin_seq #(.LEN_W(LEN_W), .CMP_LAT(CMP_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_mode    (i_mode),
    .i_len     (i_len),
    .i_abort   (i_abort),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_res     (o_res),
    .o_idx     (o_idx),
    .o_nan     (o_nan),
    .o_len_err (o_len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start a reduction and feed vec[0..n-1]; optionally abort during CMP after abort_k
  // handshakes, or pulse rst after rst_k handshakes. Sampling happens 1 time unit after posedge.
  task automatic run(input logic md, input int n, input int abort_k, input int rst_k);
    int k, gap_cur, stop_cyc, snap_cyc;
    logic will_hs;
    done_cnt = 0; ready_cnt = 0; done_cyc = -1; last_hs = -1;
    k = 0; gap_cur = 0; stop_cyc = -1; snap_cyc = -1; fired = 1'b0;
    for (int j = 0; j < 256; j++) gap_before[j] = 0;
    i_mode  = md;
    i_len   = n[7:0];
    i_start = 1'b1;
    s_valid = 1'b1;
    if (n > 0) s_data = vec[0];
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == snap_cyc) begin
        snap_flags = {s_ready, o_busy, o_done, o_nan, o_len_err};
        snap_res   = o_res;
        snap_idx   = o_idx;
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          got_res  = o_res;
          got_idx  = o_idx;
          got_nan  = o_nan;
          got_lerr = o_len_err;
        end
      end
      if (done_cnt > 0 && cyc >= done_cyc + 3) break;
      if (stop_cyc >= 0 && cyc >= stop_cyc) break;
      will_hs = s_ready && (k < n);
      if (s_ready) ready_cnt++;
      if (!s_ready && k > 0 && k < n) gap_cur++;
      if (will_hs) last_hs = cyc;
      if (!fired && abort_k >= 0 && k == abort_k && !s_ready && o_busy) begin
        i_abort = 1'b1; fired = 1'b1; snap_cyc = cyc + 1; stop_cyc = cyc + 8;
      end
      if (!fired && rst_k >= 0 && k == rst_k) begin
        rst = 1'b1; fired = 1'b1; snap_cyc = cyc + 1; stop_cyc = cyc + 2;
      end
      @(posedge clk); #1;
      i_start = 1'b0;
      i_abort = 1'b0;
      rst     = 1'b0;
      if (will_hs) begin
        gap_before[k] = gap_cur;
        gap_cur = 0;
        k++;
        if (k < n) s_data = vec[k];
      end
    end
    if (done_cnt == 0 && stop_cyc < 0) $display("FAIL run_timeout got=no_done exp=done");
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_len = '0; i_abort = 1'b0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {27'd0, s_ready, o_busy, o_done, o_nan, o_len_err}, 32'd0);
    chk("rst_res", o_res, 32'h0);
    chk("rst_idx", {24'd0, o_idx}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Max of {1.0, -2.0, 3.5, 3.5}: 3.5 at index 2, tie at index 3 loses.
    vec[0] = 32'h3F800000; vec[1] = 32'hC0000000; vec[2] = 32'h40600000; vec[3] = 32'h40600000;
    run(1'b0, 4, -1, -1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_res", got_res, 32'h40600000);
    chk("t1_idx", {24'd0, got_idx}, 32'd2);
    chk("t1_nan", {31'd0, got_nan}, 32'd0);
    chk("t1_gap_first", gap_before[1], 0);
    chk("t1_gap_e1", gap_before[2], CMP_LAT);
    chk("t1_gap_e2", gap_before[3], CMP_LAT);
    chk("t1_lat", done_cyc - last_hs, CMP_LAT + 1);

    // Min of {+0, -0, +Inf}: zeros tie, earliest kept.
    vec[0] = 32'h00000000; vec[1] = 32'h80000000; vec[2] = 32'h7F800000;
    run(1'b1, 3, -1, -1);
    chk("t2_res", got_res, 32'h00000000);
    chk("t2_idx", {24'd0, got_idx}, 32'd0);

    // Max with NaNs around -Inf; last element NaN so done follows 1 cycle later.
    vec[0] = 32'h7FC00001; vec[1] = 32'hFF800000; vec[2] = 32'h7F800001;
    run(1'b0, 3, -1, -1);
    chk("t3_res", got_res, 32'hFF800000);
    chk("t3_idx", {24'd0, got_idx}, 32'd1);
    chk("t3_nan", {31'd0, got_nan}, 32'd1);
    chk("t3_lat", done_cyc - last_hs, 1);

    // All NaN.
    vec[0] = 32'h7FC00001; vec[1] = 32'h7F800001;
    run(1'b0, 2, -1, -1);
    chk("t4_res", got_res, 32'h7FC00000);
    chk("t4_idx", {24'd0, got_idx}, 32'd0);
    chk("t4_nan", {31'd0, got_nan}, 32'd1);

    // Zero length.
    run(1'b0, 0, -1, -1);
    chk("t5_done_cyc", done_cyc, 1);
    chk("t5_lerr", {31'd0, got_lerr}, 32'd1);
    chk("t5_res", got_res, 32'h7FC00000);
    chk("t5_idx", {24'd0, got_idx}, 32'd0);
    chk("t5_ready_cnt", ready_cnt, 0);

    // Min of {2.0, -1.0, 4.0}; length error clears on this start.
    vec[0] = 32'h40000000; vec[1] = 32'hBF800000; vec[2] = 32'h40800000;
    run(1'b1, 3, -1, -1);
    chk("t6_res", got_res, 32'hBF800000);
    chk("t6_idx", {24'd0, got_idx}, 32'd1);
    chk("t6_lerr", {31'd0, got_lerr}, 32'd0);

    // Abort during the compare of element index 1 of 5.
    vec[0] = 32'h3F800000; vec[1] = 32'h40000000; vec[2] = 32'h40400000;
    vec[3] = 32'h40800000; vec[4] = 32'h40A00000;
    run(1'b0, 5, 2, -1);
    chk("ab_fired", {31'd0, fired}, 32'd1);
    chk("ab_done_cnt", done_cnt, 0);
    chk("ab_busy_ready", {30'd0, snap_flags[4], snap_flags[3]}, 32'd0);
    chk("ab_res_held", o_res, 32'hBF800000);
    chk("ab_idx_held", {24'd0, o_idx}, 32'd1);

    // Normal run after abort: {1.0, 2.0, 3.0, -Inf, 3.0} -> 3.0 at index 2.
    vec[0] = 32'h3F800000; vec[1] = 32'h40000000; vec[2] = 32'h40400000;
    vec[3] = 32'hFF800000; vec[4] = 32'h40400000;
    run(1'b0, 5, -1, -1);
    chk("t7_done_cnt", done_cnt, 1);
    chk("t7_res", got_res, 32'h40400000);
    chk("t7_idx", {24'd0, got_idx}, 32'd2);

    // Reset after two handshakes: everything returns to power-on values.
    run(1'b0, 5, -1, 2);
    chk("rm_flags", {27'd0, snap_flags}, 32'd0);
    chk("rm_res", snap_res, 32'h0);
    chk("rm_idx", {24'd0, snap_idx}, 32'd0);

    // Run after reset with s_valid held high: {+Inf, 1.0} -> +Inf at index 0.
    vec[0] = 32'h7F800000; vec[1] = 32'h3F800000;
    run(1'b0, 2, -1, -1);
    chk("t8_res", got_res, 32'h7F800000);
    chk("t8_idx", {24'd0, got_idx}, 32'd0);
    chk("t8_ready_cnt", ready_cnt, 2);

    // Maximum length 255, strictly increasing positive values: last wins, no count wrap.
    for (int j = 0; j < 255; j++) vec[j] = 32'h3F800000 + j;
    run(1'b0, 255, -1, -1);
    chk("t9_done_cnt", done_cnt, 1);
    chk("t9_res", got_res, 32'h3F8000FE);
    chk("t9_idx", {24'd0, got_idx}, 32'd254);

    s_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp32_vec_maxmin_seq.md
Name: fp32_vec_maxmin_seq

Overview:
- Sequencer that reduces a streamed vector of FP32 elements to its maximum or minimum value and the index of that element.
- Owns one ordered-compare datapath (sub-module) with a fixed CMP_LAT-cycle pipeline latency.
- Issues one compare per element, waits for the result, then updates the running best.
- Sits between a vector source (valid/ready stream) and the result consumer in the fp32_max_min subsystem.

Parameters:
- LEN_W, 8: width of vector length and index.
- CMP_LAT, 2: compare pipeline latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_start  in  1  start pulse. Sampled only in IDLE.
- i_mode  in  1  0 = max, 1 = min. Latched on an accepted i_start.
- i_len  in  LEN_W  element count. Latched on an accepted i_start.
- i_abort  in  1  abandon the current reduction.
- s_valid  in  1  element valid.
- s_ready  out  1  element accept.
- s_data  in  32  FP32 element.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle result strobe.
- o_res  out  32  selected value.
- o_idx  out  LEN_W  index of selected value.
- o_nan  out  1  at least one NaN element seen.
- o_len_err  out  1  i_len was 0.

Behaviour:
- Reset:
  - state = IDLE.
  - s_ready, o_busy, o_done, o_nan, o_len_err = 0.
  - o_res = 0, o_idx = 0.
  - Compare pipeline valid bits cleared.
- States: IDLE, ACCEPT, CMP, DONE.
- IDLE, on i_start:
  - Latch mode and len; clear count, best_valid and nan_seen.
  - If len == 0: go to DONE with o_len_err = 1, o_res = 0x7FC00000, o_idx = 0.
  - Otherwise go to ACCEPT.
- ACCEPT:
  - s_ready = 1. On handshake, capture the element and index = count, then count++.
  - NaN element (exp all ones, mantissa nonzero): set nan_seen; never selected. Go to DONE if count == len, else stay in ACCEPT.
  - Non-NaN element with best_valid == 0: becomes best (best_valid = 1, no compare). Same next-state rule.
  - Non-NaN element with best_valid == 1: launch a compare (candidate vs best) and go to CMP.
- CMP:
  - s_ready = 0. Wait exactly CMP_LAT cycles.
  - On the result cycle: replace best if the candidate is strictly greater (max) or strictly less (min).
  - Ties keep the earlier index. +0 and -0 compare equal. Infinities order normally.
  - Then go to DONE if count == len, else ACCEPT.
- DONE: one cycle.
  - o_done = 1.
  - o_res = best, or 0x7FC00000 if best_valid == 0 (all elements NaN).
  - o_idx = best index (0 if none).
  - o_nan = nan_seen.
  - Next state IDLE.
- Output hold: o_res, o_idx, o_nan and o_len_err hold until the next accepted i_start. o_len_err clears on that start.
- Throughput: a compared element costs CMP_LAT+1 cycles. A first/NaN element costs 1 cycle.
- Latency: last handshake to o_done is CMP_LAT+1 cycles if that element was compared, else 1 cycle.
- i_start outside IDLE: ignored.
- i_abort in any non-IDLE state: IDLE next cycle, no o_done, compare pipeline flushed, outputs keep their previous result.
- i_abort and i_start in the same cycle in IDLE: start wins.
- Reset mid-operation: identical to power-on reset.
- count is LEN_W bits; i_len = 2^LEN_W - 1 is the maximum and must not wrap.
- s_valid while s_ready = 0 is held by the source; no element is dropped.

Decomposition:
- Package fp32_pkg holds:
  - FP32 field widths (sign/exp/mant = 1/8/23).
  - QNAN constant 0x7FC00000.
  - Mode encodings MODE_MAX = 0, MODE_MIN = 1.
  - State enum.
  - is_nan function.
- One sub-module, fp32_ord_cmp: ordered compare of a vs b producing gt/lt/eq.
  - Sign-magnitude ordering with the ±0 equality rule.
  - Followed by CMP_LAT registers carrying valid and result.
  - Synchronous flush input.

Test Plan:
- Max, len = 4, data {1.0 (0x3F800000), -2.0 (0xC0000000), 3.5 (0x40600000), 3.5} → o_done once, o_res = 0x40600000, o_idx = 2, o_nan = 0; s_ready low exactly CMP_LAT cycles after each of elements 1-3.
- Min, len = 3, data {+0 (0x00000000), -0 (0x80000000), +Inf (0x7F800000)} → o_res = 0x00000000, o_idx = 0 (tie keeps earliest).
- Max, len = 3, data {NaN 0x7FC00001, -Inf 0xFF800000, NaN 0x7F800001} → o_res = 0xFF800000, o_idx = 1, o_nan = 1. All-NaN len = 2 → o_res = 0x7FC00000, o_idx = 0, o_nan = 1.
- i_start with i_len = 0 → o_done 1 cycle later, o_len_err = 1, o_res = 0x7FC00000, no s_ready pulse.
- i_abort asserted during CMP of element 2 of 5 → IDLE next cycle, no o_done, previous o_res held; new i_start then runs normally to completion.
- rst asserted mid-vector → all outputs 0 next cycle; i_start with s_valid held high throughout the run → correct result, one element per handshake.
